// File: rtl/score_scan_driver.sv
// Binary score to 4-digit BCD (sequential double-dabble) plus a multiplexed
// common-anode scan driver feeding one BCD nibble per slot to the 7-seg decoder.
module score_scan_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BIN_W       = 14,
  parameter bit          LZ_BLANK    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [BIN_W-1:0] bin_in,
  input  logic             load,
  output logic             busy,
  output logic [15:0]      digits,
  output logic [3:0]       bcd_out,
  output logic [3:0]       an
);

  localparam int unsigned PW   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned CW   = $clog2(BIN_W + 1);
  localparam int unsigned MAXV = 9999;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] shift_q, shift_nxt;
  logic [15:0]      acc_q, acc_nxt, acc_adj;
  logic [CW-1:0]    cnt_q, cnt_nxt;
  logic [15:0]      digits_nxt;
  logic             busy_nxt;
  logic [BIN_W-1:0] clamp_c;

  logic [PW-1:0]    presc;
  logic [1:0]       idx;
  logic             lead_zero;

  // Scores above 9999 saturate so the result always fits four digits
  always_comb begin
    clamp_c = bin_in;
    if (32'(bin_in) > 32'(MAXV)) clamp_c = BIN_W'(MAXV);
  end

  // Add-3 correction on every BCD nibble that is 5 or more
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < 4; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    shift_nxt  = shift_q;
    acc_nxt    = acc_q;
    cnt_nxt    = cnt_q;
    digits_nxt = digits;
    busy_nxt   = busy;
    unique case (state)
      IDLE: begin
        if (load) begin
          shift_nxt = clamp_c;
          acc_nxt   = '0;
          cnt_nxt   = CW'(BIN_W);
          busy_nxt  = 1'b1;
          state_nxt = CONV;
        end
      end
      CONV: begin
        acc_nxt   = {acc_adj[14:0], shift_q[BIN_W-1]};
        shift_nxt = {shift_q[BIN_W-2:0], 1'b0};
        cnt_nxt   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_nxt = DONE;
      end
      DONE: begin
        digits_nxt = acc_q;
        busy_nxt   = 1'b0;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      digits  <= '0;
      busy    <= 1'b0;
    end else begin
      shift_q <= shift_nxt;
      acc_q   <= acc_nxt;
      cnt_q   <= cnt_nxt;
      digits  <= digits_nxt;
      busy    <= busy_nxt;
    end
  end

  // Free-running slot timer; the digit index advances on each wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      idx   <= 2'd0;
    end else if (presc == PW'(REFRESH_DIV - 1)) begin
      presc <= '0;
      idx   <= idx + 2'd1;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // A position is a leading zero when it and every higher digit are zero
  always_comb begin
    lead_zero = 1'b0;
    unique case (idx)
      2'd1:    lead_zero = (digits[15:4]  == 12'h000);
      2'd2:    lead_zero = (digits[15:8]  == 8'h00);
      2'd3:    lead_zero = (digits[15:12] == 4'h0);
      default: lead_zero = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out <= 4'h0;
      an      <= 4'b1111;
    end else begin
      bcd_out <= digits[4*idx +: 4];
      an      <= (LZ_BLANK && lead_zero) ? 4'b1111 : ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_score_scan_driver.sv
// Randomized self-checking bench for score_scan_driver; a decimal-arithmetic
// model predicts the latched digits and the per-slot anode/nibble outputs.
module tb_score_scan_driver;

  localparam int unsigned BW = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [BW-1:0] bin_in = '0;
  logic          load = 1'b0;
  logic          busy, busy_nb;
  logic [15:0]   digits, digits_nb;
  logic [3:0]    bcd_out, an, bcd_nb, an_nb;

  int checks = 0;
  int errors = 0;
  int cyc;
  int model = 0;

  always #5 clk = ~clk;

  // Edges since reset release; slot index of the output seen after edge k is ((k-1)/4)%4
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  score_scan_driver #(.REFRESH_DIV(4), .BIN_W(BW), .LZ_BLANK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
    .busy(busy), .digits(digits), .bcd_out(bcd_out), .an(an));

  score_scan_driver #(.REFRESH_DIV(4), .BIN_W(BW), .LZ_BLANK(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .bin_in(bin_in), .load(load),
    .busy(busy_nb), .digits(digits_nb), .bcd_out(bcd_nb), .an(an_nb));

  function automatic int dig(int v, int i);
    int p;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(int v);
    return {4'(dig(v, 3)), 4'(dig(v, 2)), 4'(dig(v, 1)), 4'(dig(v, 0))};
  endfunction

  function automatic logic [3:0] exp_an(int v, int k, bit lz);
    int i;
    int p;
    i = ((k - 1) / 4) % 4;
    p = 1;
    for (int j = 0; j < i; j++) p = p * 10;
    if (lz && i > 0 && v < p) return 4'b1111;
    return ~(4'b0001 << i);
  endfunction

  function automatic logic [3:0] exp_bcd(int v, int k);
    return 4'(dig(v, ((k - 1) / 4) % 4));
  endfunction

  // One conversion: optional extra load pulse at busy-cycle inj_at (must be dropped)
  task automatic run_conv(input int v, input int inj_at, input int inj_val);
    int n;
    int old;
    int expv;
    old  = model;
    expv = (v > 9999) ? 9999 : v;
    @(negedge clk);
    bin_in = BW'(v);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    bin_in = BW'($urandom);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      if (n == inj_at) begin
        bin_in = BW'(inj_val);
        load   = 1'b1;
      end
      checks++;
      if (digits !== to_bcd(old)) begin
        errors++;
        $display("FAIL partial_digits v=%0d got=%h exp=%h", v, digits, to_bcd(old));
      end
      checks++;
      if (an !== exp_an(old, cyc, 1'b1) || bcd_out !== exp_bcd(old, cyc)) begin
        errors++;
        $display("FAIL scan_during_conv got an=%b bcd=%h exp an=%b bcd=%h",
                 an, bcd_out, exp_an(old, cyc, 1'b1), exp_bcd(old, cyc));
      end
      @(negedge clk);
      load = 1'b0;
    end
    checks++;
    if (n != 15) begin
      errors++;
      $display("FAIL busy_len v=%0d got=%0d exp=15", v, n);
    end
    checks++;
    if (busy !== 1'b0 || digits !== to_bcd(expv)) begin
      errors++;
      $display("FAIL result v=%0d got busy=%b digits=%h exp busy=0 digits=%h",
               v, busy, digits, to_bcd(expv));
    end
    checks++;
    if (an !== exp_an(old, cyc, 1'b1) || bcd_out !== exp_bcd(old, cyc)) begin
      errors++;
      $display("FAIL scan_done_edge got an=%b bcd=%h exp an=%b bcd=%h",
               an, bcd_out, exp_an(old, cyc, 1'b1), exp_bcd(old, cyc));
    end
    model = expv;
  endtask

  task automatic test_scan(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      checks++;
      if (an !== exp_an(model, cyc, 1'b1) || bcd_out !== exp_bcd(model, cyc)) begin
        errors++;
        $display("FAIL scan_lz v=%0d cyc=%0d got an=%b bcd=%h exp an=%b bcd=%h", model, cyc,
                 an, bcd_out, exp_an(model, cyc, 1'b1), exp_bcd(model, cyc));
      end
      checks++;
      if (an_nb !== exp_an(model, cyc, 1'b0) || bcd_nb !== exp_bcd(model, cyc) ||
          digits_nb !== to_bcd(model)) begin
        errors++;
        $display("FAIL scan_nolz v=%0d cyc=%0d got an=%b bcd=%h dig=%h exp an=%b bcd=%h dig=%h",
                 model, cyc, an_nb, bcd_nb, digits_nb, exp_an(model, cyc, 1'b0),
                 exp_bcd(model, cyc), to_bcd(model));
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || digits !== 16'h0000 || an !== 4'b1111 || bcd_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_state got busy=%b digits=%h an=%b bcd=%h exp 0 0000 1111 0",
               busy, digits, an, bcd_out);
    end
    rst_n = 1'b1;
    model = 0;
    @(negedge clk);
    checks++;
    if (an !== 4'b1110 || bcd_out !== 4'h0) begin
      errors++;
      $display("FAIL first_out got an=%b bcd=%h exp an=1110 bcd=0", an, bcd_out);
    end
  endtask

  task automatic test_conversion();
    run_conv(1234, -1, 0);
    test_scan(20);
  endtask

  task automatic test_clamp();
    run_conv(16383, -1, 0);
    test_scan(8);
    run_conv(9999, -1, 0);
    test_scan(8);
    run_conv(0, -1, 0);
    test_scan(16);
  endtask

  task automatic test_blank();
    run_conv(405, -1, 0);
    test_scan(20);
  endtask

  task automatic test_load_busy();
    run_conv(1234, 5, 42);
    test_scan(4);
    run_conv(42, -1, 0);
    test_scan(16);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bin_in = BW'(1234);
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || digits !== 16'h0000 || an !== 4'b1111 || bcd_out !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid got busy=%b digits=%h an=%b bcd=%h exp 0 0000 1111 0",
               busy, digits, an, bcd_out);
    end
    model = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_after got busy=%b digits=%h exp busy=0 digits=0000", busy, digits);
    end
    test_scan(8);
  endtask

  task automatic test_random();
    int v;
    int inj;
    for (int t = 0; t < 30; t++) begin
      v   = int'($urandom_range(0, 16383));
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 14)) : -1;
      run_conv(v, inj, int'($urandom_range(0, 16383)));
      test_scan(int'($urandom_range(1, 10)));
    end
  endtask

  initial begin
    test_reset();
    test_conversion();
    test_clamp();
    test_blank();
    test_load_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
